// File: rtl/ysyx_040729_mul_pkg.sv
// Shared encodings for the EXE multiply sequencer: op codes, signedness, FSM states.
package ysyx_040729_mul_pkg;

  localparam int unsigned OP_W  = 3;
  localparam int unsigned SGN_W = 2;

  localparam logic [OP_W-1:0] OP_MUL    = 3'd0;
  localparam logic [OP_W-1:0] OP_MULH   = 3'd1;
  localparam logic [OP_W-1:0] OP_MULHSU = 3'd2;
  localparam logic [OP_W-1:0] OP_MULHU  = 3'd3;
  localparam logic [OP_W-1:0] OP_MULW   = 3'd4;

  localparam logic [SGN_W-1:0] SGN_SS = 2'b11;
  localparam logic [SGN_W-1:0] SGN_SU = 2'b10;
  localparam logic [SGN_W-1:0] SGN_UU = 2'b00;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_RESP
  } mul_state_e;

  // Reserved encodings complete as a plain MUL.
  function automatic logic [OP_W-1:0] op_norm(input logic [OP_W-1:0] op);
    return (op > OP_MULW) ? OP_MUL : op;
  endfunction

  function automatic logic [SGN_W-1:0] op_sgn(input logic [OP_W-1:0] op);
    logic [SGN_W-1:0] sgn;
    case (op)
      OP_MULHSU: sgn = SGN_SU;
      OP_MULHU:  sgn = SGN_UU;
      default:   sgn = SGN_SS;
    endcase
    return sgn;
  endfunction

endpackage

// File: rtl/ysyx_040729_mul_result_sel.sv
// Picks the architectural result from the multiplier's hi/lo halves for a given op.
module ysyx_040729_mul_result_sel
  import ysyx_040729_mul_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic [OP_W-1:0] op,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  output logic [XLEN-1:0] data_c
);

  always_comb begin
    data_c = lo;
    case (op)
      OP_MULH, OP_MULHSU, OP_MULHU: data_c = hi;
      OP_MULW:                      data_c = {{(XLEN-32){lo[31]}}, lo[31:0]};
      default:                      data_c = lo;
    endcase
  end

endmodule

// File: rtl/ysyx_040729_exe_mul_ctrl.sv
// EXE-to-Booth-multiplier sequencer with flush handling.
// YSYX_040729_MUL_FUSE_EN adds a one-entry result cache so MUL/MULH* pairs skip the multiplier.
module ysyx_040729_exe_mul_ctrl
  import ysyx_040729_mul_pkg::*;
#(
  parameter int unsigned XLEN = 64
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [2:0]       req_op,
  input  logic [XLEN-1:0]  req_src1,
  input  logic [XLEN-1:0]  req_src2,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic [XLEN-1:0]  resp_data,
  input  logic             flush,
  output logic             mul_valid,
  output logic             mul_flush,
  output logic             mul_w,
  output logic [1:0]       mul_signed,
  output logic [XLEN-1:0]  mul_a,
  output logic [XLEN-1:0]  mul_b,
  input  logic             mul_ready,
  input  logic             mul_out_valid,
  input  logic [XLEN-1:0]  mul_res_hi,
  input  logic [XLEN-1:0]  mul_res_lo
);

  mul_state_e       state_q, state_d;
  logic [OP_W-1:0]  op_q, op_d;
  logic [XLEN-1:0]  a_q, a_d, b_q, b_d;
  logic             w_q, w_d;
  logic [SGN_W-1:0] sgn_q, sgn_d;
  logic [XLEN-1:0]  resp_data_q, resp_data_d;

  logic [OP_W-1:0]  req_op_n;
  logic [OP_W-1:0]  sel_op;
  logic [XLEN-1:0]  sel_hi, sel_lo, sel_data;

`ifdef YSYX_040729_MUL_FUSE_EN
  logic             cache_vld_q, cache_vld_d;
  logic [XLEN-1:0]  cache_hi_q, cache_hi_d, cache_lo_q, cache_lo_d;
  logic [XLEN-1:0]  cache_a_q, cache_a_d, cache_b_q, cache_b_d;
  logic [SGN_W-1:0] cache_sgn_q, cache_sgn_d;
  logic             hit_c;
`endif

  assign req_op_n = op_norm(req_op);

  // In IDLE the selector serves cache hits; otherwise it shapes the live multiplier result.
  always_comb begin
    sel_op = op_q;
    sel_hi = mul_res_hi;
    sel_lo = mul_res_lo;
`ifdef YSYX_040729_MUL_FUSE_EN
    if (state_q == ST_IDLE) begin
      sel_op = req_op_n;
      sel_hi = cache_hi_q;
      sel_lo = cache_lo_q;
    end
`endif
  end

  ysyx_040729_mul_result_sel #(.XLEN(XLEN)) u_result_sel (
    .op     (sel_op),
    .hi     (sel_hi),
    .lo     (sel_lo),
    .data_c (sel_data)
  );

`ifdef YSYX_040729_MUL_FUSE_EN
  // MUL only reuses a fully signed entry; MULH* need an exact signedness match.
  always_comb begin
    hit_c = 1'b0;
    if (cache_vld_q && (req_src1 == cache_a_q) && (req_src2 == cache_b_q)) begin
      if (req_op_n == OP_MUL) begin
        hit_c = (cache_sgn_q == SGN_SS);
      end else if (req_op_n != OP_MULW) begin
        hit_c = (cache_sgn_q == op_sgn(req_op_n));
      end
    end
  end
`endif

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    w_d         = w_q;
    sgn_d       = sgn_q;
    resp_data_d = resp_data_q;
    mul_flush   = 1'b0;
`ifdef YSYX_040729_MUL_FUSE_EN
    cache_vld_d = cache_vld_q;
    cache_hi_d  = cache_hi_q;
    cache_lo_d  = cache_lo_q;
    cache_a_d   = cache_a_q;
    cache_b_d   = cache_b_q;
    cache_sgn_d = cache_sgn_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (req_valid && !flush) begin
          op_d    = req_op_n;
          a_d     = req_src1;
          b_d     = req_src2;
          w_d     = (req_op_n == OP_MULW);
          sgn_d   = op_sgn(req_op_n);
          state_d = ST_ISSUE;
`ifdef YSYX_040729_MUL_FUSE_EN
          if (hit_c) begin
            resp_data_d = sel_data;
            state_d     = ST_RESP;
          end
`endif
        end
      end
      ST_ISSUE: begin
        if (flush) begin
          mul_flush = 1'b1;
          state_d   = ST_IDLE;
        end else if (mul_ready) begin
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (flush) begin
          mul_flush = 1'b1;
          state_d   = ST_IDLE;
        end else if (mul_out_valid) begin
          resp_data_d = sel_data;
          state_d     = ST_RESP;
`ifdef YSYX_040729_MUL_FUSE_EN
          if (op_q != OP_MULW) begin
            cache_vld_d = 1'b1;
            cache_hi_d  = mul_res_hi;
            cache_lo_d  = mul_res_lo;
            cache_a_d   = a_q;
            cache_b_d   = b_q;
            cache_sgn_d = sgn_q;
          end
`endif
        end
      end
      ST_RESP: begin
        if (flush || resp_ready) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef YSYX_040729_MUL_FUSE_EN
    if (flush) begin
      cache_vld_d = 1'b0;
    end
`endif
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      op_q        <= OP_MUL;
      a_q         <= '0;
      b_q         <= '0;
      w_q         <= 1'b0;
      sgn_q       <= SGN_UU;
      resp_data_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      w_q         <= w_d;
      sgn_q       <= sgn_d;
      resp_data_q <= resp_data_d;
    end
  end

`ifdef YSYX_040729_MUL_FUSE_EN
  always_ff @(posedge clock) begin
    if (reset) begin
      cache_vld_q <= 1'b0;
      cache_hi_q  <= '0;
      cache_lo_q  <= '0;
      cache_a_q   <= '0;
      cache_b_q   <= '0;
      cache_sgn_q <= SGN_UU;
    end else begin
      cache_vld_q <= cache_vld_d;
      cache_hi_q  <= cache_hi_d;
      cache_lo_q  <= cache_lo_d;
      cache_a_q   <= cache_a_d;
      cache_b_q   <= cache_b_d;
      cache_sgn_q <= cache_sgn_d;
    end
  end
`endif

  assign req_ready  = (state_q == ST_IDLE);
  assign resp_valid = (state_q == ST_RESP);
  assign mul_valid  = (state_q == ST_ISSUE);
  assign resp_data  = resp_data_q;
  assign mul_w      = w_q;
  assign mul_signed = sgn_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;

endmodule

// File: tb/tb_ysyx_040729_exe_mul_ctrl.sv
// Scoreboard bench for ysyx_040729_exe_mul_ctrl with a behavioural variable-latency multiplier.
module tb_ysyx_040729_exe_mul_ctrl;
  import ysyx_040729_mul_pkg::*;

  localparam int unsigned XLEN = 64;

  logic            clock;
  logic            reset;
  logic            req_valid, req_ready;
  logic [2:0]      req_op;
  logic [XLEN-1:0] req_src1, req_src2;
  logic            resp_valid, resp_ready;
  logic [XLEN-1:0] resp_data;
  logic            flush;
  logic            mul_valid, mul_flush, mul_w;
  logic [1:0]      mul_signed;
  logic [XLEN-1:0] mul_a, mul_b;
  logic            mul_ready, mul_out_valid;
  logic [XLEN-1:0] mul_res_hi, mul_res_lo;

  ysyx_040729_exe_mul_ctrl #(.XLEN(XLEN)) dut (
    .clock         (clock),
    .reset         (reset),
    .req_valid     (req_valid),
    .req_ready     (req_ready),
    .req_op        (req_op),
    .req_src1      (req_src1),
    .req_src2      (req_src2),
    .resp_valid    (resp_valid),
    .resp_ready    (resp_ready),
    .resp_data     (resp_data),
    .flush         (flush),
    .mul_valid     (mul_valid),
    .mul_flush     (mul_flush),
    .mul_w         (mul_w),
    .mul_signed    (mul_signed),
    .mul_a         (mul_a),
    .mul_b         (mul_b),
    .mul_ready     (mul_ready),
    .mul_out_valid (mul_out_valid),
    .mul_res_hi    (mul_res_hi),
    .mul_res_lo    (mul_res_lo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_acc = 0;
  logic [63:0] exp_q[$];

  always @(posedge clock) cyc <= cyc + 1;

  // Multiplier model: latency counts from the mul_valid cycle to the mul_out_valid cycle.
  int          mul_lat = 3;
  bit          mul_stall = 1'b0;
  logic        busy;
  int          cnt;
  logic [63:0] pend_hi, pend_lo;
  int          mv_cycles = 0;
  logic        last_w;
  logic [1:0]  last_sgn;
  logic [127:0] ea, eb, prod;

  assign mul_ready = !busy && !mul_stall;

  always_comb begin
    ea = mul_signed[1] ? {{64{mul_a[63]}}, mul_a} : {64'd0, mul_a};
    eb = mul_signed[0] ? {{64{mul_b[63]}}, mul_b} : {64'd0, mul_b};
    if (mul_w) begin
      ea = {{96{mul_a[31]}}, mul_a[31:0]};
      eb = {{96{mul_b[31]}}, mul_b[31:0]};
    end
    prod = ea * eb;
  end

  always @(posedge clock) begin
    if (mul_valid === 1'b1) mv_cycles <= mv_cycles + 1;
    mul_out_valid <= 1'b0;
    if (reset || mul_flush) begin
      busy <= 1'b0;
    end else if (busy) begin
      cnt <= cnt - 1;
      if (cnt == 1) begin
        busy          <= 1'b0;
        mul_out_valid <= 1'b1;
        mul_res_hi    <= pend_hi;
        mul_res_lo    <= pend_lo;
      end
    end else if (mul_valid && mul_ready) begin
      last_w   <= mul_w;
      last_sgn <= mul_signed;
      if (mul_lat <= 1) begin
        mul_out_valid <= 1'b1;
        mul_res_hi    <= prod[127:64];
        mul_res_lo    <= prod[63:0];
      end else begin
        busy    <= 1'b1;
        cnt     <= mul_lat - 1;
        pend_hi <= prod[127:64];
        pend_lo <= prod[63:0];
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  // Architectural RV64M reference, written from the op directly.
  function automatic logic [63:0] ref_res(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b);
    logic [127:0] sa, za, sb, zb, p;
    logic [63:0]  wp, r;
    sa = {{64{a[63]}}, a};
    za = {64'd0, a};
    sb = {{64{b[63]}}, b};
    zb = {64'd0, b};
    wp = {{32{a[31]}}, a[31:0]} * {{32{b[31]}}, b[31:0]};
    p  = za * zb;
    case (op)
      3'd1:    begin p = sa * sb; r = p[127:64]; end
      3'd2:    begin p = sa * zb; r = p[127:64]; end
      3'd3:    r = p[127:64];
      3'd4:    r = {{32{wp[31]}}, wp[31:0]};
      default: r = p[63:0];
    endcase
    return r;
  endfunction

  // Drives one request in the current cycle; it is accepted at the next edge.
  task automatic do_req(input logic [2:0] op, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] exp, input bit push);
    req_valid = 1'b1;
    req_op    = op;
    req_src1  = a;
    req_src2  = b;
    last_acc  = cyc;
    if (push) exp_q.push_back(exp);
    @(negedge clock);
    req_valid = 1'b0;
  endtask

  // Waits (bounded) for resp_valid, then completes the handshake.
  task automatic get_resp(output logic [63:0] d, output int lat, output bit ok);
    ok  = 1'b0;
    d   = '0;
    lat = 0;
    for (int i = 0; i < 200 && !ok; i++) begin
      if (resp_valid === 1'b1) ok = 1'b1;
      else @(negedge clock);
    end
    if (ok) begin
      d          = resp_data;
      lat        = cyc - last_acc;
      resp_ready = 1'b1;
      @(negedge clock);
      resp_ready = 1'b0;
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL rst_req_ready got %b exp 1", req_ready); end
    checks++; if (resp_valid !== 1'b0) begin errors++; $display("FAIL rst_resp_valid got %b exp 0", resp_valid); end
    checks++; if (resp_data !== 64'd0) begin errors++; $display("FAIL rst_resp_data got %h exp 0", resp_data); end
    checks++; if (mul_valid !== 1'b0 || mul_flush !== 1'b0) begin errors++; $display("FAIL rst_mul_ctl got v=%b f=%b exp 0/0", mul_valid, mul_flush); end
    checks++; if (mul_w !== 1'b0 || mul_signed !== 2'b00) begin errors++; $display("FAIL rst_mul_mode got w=%b s=%b exp 0/00", mul_w, mul_signed); end
    checks++; if (mul_a !== 64'd0 || mul_b !== 64'd0) begin errors++; $display("FAIL rst_mul_ops got a=%h b=%h exp 0/0", mul_a, mul_b); end
  endtask

  task automatic test_mul_basic;
    logic [63:0] d, e;
    int lat, mv0;
    bit ok;
    mul_lat = 4;
    mv0 = mv_cycles;
    do_req(3'd0, 64'd3, 64'd5, 64'd15, 1'b1);
    get_resp(d, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e) begin errors++; $display("FAIL mul_data got %h exp %h ok=%0d", d, e, ok); end
    checks++; if (lat !== mul_lat + 2) begin errors++; $display("FAIL mul_latency got %0d exp %0d", lat, mul_lat + 2); end
    checks++; if (last_sgn !== 2'b11 || last_w !== 1'b0) begin errors++; $display("FAIL mul_mode got s=%b w=%b exp 11/0", last_sgn, last_w); end
    checks++; if (mv_cycles - mv0 !== 1) begin errors++; $display("FAIL mul_valid_cycles got %0d exp 1", mv_cycles - mv0); end
  endtask

  task automatic test_mulh_variants;
    logic [63:0] d, e;
    logic [2:0]  ops[3]  = '{3'd1, 3'd3, 3'd2};
    logic [63:0] as[3]   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [63:0] bs[3]   = '{64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2};
    logic [63:0] exps[3] = '{64'd0, 64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_FFFF_FFFF};
    logic [1:0]  sgns[3] = '{2'b11, 2'b00, 2'b10};
    int lat;
    bit ok;
    mul_lat = 6;
    for (int i = 0; i < 3; i++) begin
      do_req(ops[i], as[i], bs[i], exps[i], 1'b1);
      get_resp(d, lat, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || d !== e) begin errors++; $display("FAIL mulh_data[%0d] got %h exp %h", i, d, e); end
      checks++; if (last_sgn !== sgns[i]) begin errors++; $display("FAIL mulh_sgn[%0d] got %b exp %b", i, last_sgn, sgns[i]); end
    end
  endtask

  task automatic test_mulw_reserved;
    logic [63:0] d, e;
    int lat;
    bit ok;
    mul_lat = 3;
    do_req(3'd4, 64'h7FFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    get_resp(d, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e) begin errors++; $display("FAIL mulw_data got %h exp %h", d, e); end
    checks++; if (last_w !== 1'b1 || last_sgn !== 2'b11) begin errors++; $display("FAIL mulw_mode got w=%b s=%b exp 1/11", last_w, last_sgn); end
    do_req(3'd5, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    get_resp(d, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e) begin errors++; $display("FAIL reserved_data got %h exp %h", d, e); end
    checks++; if (last_w !== 1'b0 || last_sgn !== 2'b11) begin errors++; $display("FAIL reserved_mode got w=%b s=%b exp 0/11", last_w, last_sgn); end
  endtask

  task automatic test_flush_wait;
    logic [63:0] d, e;
    int lat;
    bit ok, seen;
    mul_lat = 10;
    do_req(3'd0, 64'd9, 64'd9, 64'd0, 1'b0);
    repeat (5) @(negedge clock);
    flush = 1'b1;
    #1;
    checks++; if (mul_flush !== 1'b1) begin errors++; $display("FAIL flush_wait_pulse got %b exp 1", mul_flush); end
    @(negedge clock);
    flush = 1'b0;
    #1;
    checks++; if (mul_flush !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL flush_wait_after got f=%b rdy=%b exp 0/1", mul_flush, req_ready); end
    seen = 1'b0;
    repeat (15) begin
      @(negedge clock);
      if (resp_valid !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen) begin errors++; $display("FAIL flush_wait_noresp got 1 exp 0"); end
    do_req(3'd0, 64'd7, 64'd6, 64'd42, 1'b1);
    get_resp(d, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e) begin errors++; $display("FAIL flush_wait_next got %h exp %h", d, e); end
  endtask

  task automatic test_flush_issue;
    mul_lat   = 3;
    mul_stall = 1'b1;
    do_req(3'd1, 64'd11, 64'd13, 64'd0, 1'b0);
    repeat (3) @(negedge clock);
    checks++; if (mul_valid !== 1'b1) begin errors++; $display("FAIL issue_hold got %b exp 1", mul_valid); end
    flush = 1'b1;
    #1;
    checks++; if (mul_flush !== 1'b1) begin errors++; $display("FAIL issue_flush_pulse got %b exp 1", mul_flush); end
    @(negedge clock);
    flush     = 1'b0;
    mul_stall = 1'b0;
    #1;
    checks++; if (mul_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL issue_flush_after got v=%b rdy=%b exp 0/1", mul_valid, req_ready); end
    @(negedge clock);
  endtask

  task automatic test_flush_req;
    bit seen;
    req_valid = 1'b1;
    req_op    = 3'd0;
    req_src1  = 64'd4;
    req_src2  = 64'd4;
    flush     = 1'b1;
    #1;
    checks++; if (mul_flush !== 1'b0) begin errors++; $display("FAIL idle_flush_pulse got %b exp 0", mul_flush); end
    @(negedge clock);
    req_valid = 1'b0;
    flush     = 1'b0;
    seen      = 1'b0;
    repeat (10) begin
      if (mul_valid !== 1'b0 || resp_valid !== 1'b0 || req_ready !== 1'b1) seen = 1'b1;
      @(negedge clock);
    end
    checks++; if (seen) begin errors++; $display("FAIL req_drop got activity exp none"); end
  endtask

  task automatic test_backpressure;
    logic [63:0] e;
    bit ok;
    mul_lat = 2;
    do_req(3'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFE, 1'b1);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      if (resp_valid === 1'b1) ok = 1'b1;
      else @(negedge clock);
    end
    e = exp_q.pop_front();
    checks++; if (!ok) begin errors++; $display("FAIL bp_timeout got 0 exp 1"); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (resp_valid !== 1'b1 || resp_data !== e || req_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_hold[%0d] got v=%b d=%h rdy=%b exp 1/%h/0", i, resp_valid, resp_data, req_ready, e);
      end
    end
    resp_ready = 1'b1;
    @(negedge clock);
    resp_ready = 1'b0;
    checks++; if (resp_valid !== 1'b0 || req_ready !== 1'b1) begin errors++; $display("FAIL bp_release got v=%b rdy=%b exp 0/1", resp_valid, req_ready); end
  endtask

  task automatic test_back_to_back;
    logic [63:0] d, e, a, b;
    logic [2:0]  op;
    int lat, prev_acc;
    bit ok;
    mul_lat  = 5;
    prev_acc = 0;
    for (int k = 0; k < 4; k++) begin
      op = 3'($urandom_range(0, 7));
      a  = {$urandom, $urandom};
      b  = {$urandom, $urandom};
      checks++; if (req_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready[%0d] got %b exp 1", k, req_ready); end
      do_req(op, a, b, ref_res(op, a, b), 1'b1);
      if (k > 0) begin
        checks++;
        if (last_acc - prev_acc !== mul_lat + 3) begin
          errors++;
          $display("FAIL b2b_spacing[%0d] got %0d exp %0d", k, last_acc - prev_acc, mul_lat + 3);
        end
      end
      prev_acc = last_acc;
      get_resp(d, lat, ok);
      e = exp_q.pop_front();
      checks++; if (!ok || d !== e) begin errors++; $display("FAIL b2b_data[%0d] op=%0d got %h exp %h", k, op, d, e); end
    end
  endtask

`ifdef YSYX_040729_MUL_FUSE_EN
  task automatic test_fuse;
    logic [63:0] d, e;
    int lat, mv0;
    bit ok;
    mul_lat = 4;
    do_req(3'd1, 64'h1_0000_0000, 64'h1_0000_0003, 64'd1, 1'b1);
    get_resp(d, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e) begin errors++; $display("FAIL fuse_mulh got %h exp %h", d, e); end
    mv0 = mv_cycles;
    do_req(3'd0, 64'h1_0000_0000, 64'h1_0000_0003, 64'h3_0000_0000, 1'b1);
    get_resp(d, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e) begin errors++; $display("FAIL fuse_hit_data got %h exp %h", d, e); end
    checks++; if (lat !== 1 || mv_cycles - mv0 !== 0) begin errors++; $display("FAIL fuse_hit_timing got lat=%0d mv=%0d exp 1/0", lat, mv_cycles - mv0); end
    flush = 1'b1;
    @(negedge clock);
    flush = 1'b0;
    mv0 = mv_cycles;
    do_req(3'd0, 64'h1_0000_0000, 64'h1_0000_0003, 64'h3_0000_0000, 1'b1);
    get_resp(d, lat, ok);
    e = exp_q.pop_front();
    checks++; if (!ok || d !== e) begin errors++; $display("FAIL fuse_miss_data got %h exp %h", d, e); end
    checks++; if (lat !== mul_lat + 2 || mv_cycles - mv0 !== 1) begin errors++; $display("FAIL fuse_miss_timing got lat=%0d mv=%0d exp %0d/1", lat, mv_cycles - mv0, mul_lat + 2); end
  endtask
`endif

  initial begin
    reset      = 1'b1;
    req_valid  = 1'b0;
    req_op     = 3'd0;
    req_src1   = '0;
    req_src2   = '0;
    resp_ready = 1'b0;
    flush      = 1'b0;
    @(negedge clock);
    test_reset();
    test_mul_basic();
    test_mulh_variants();
    test_mulw_reserved();
    test_flush_wait();
    test_flush_issue();
    test_flush_req();
    test_backpressure();
    test_back_to_back();
`ifdef YSYX_040729_MUL_FUSE_EN
    test_fuse();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ysyx_040729_exe_mul_ctrl.md
# ysyx_040729_exe_mul_ctrl

Sequencer that sits between the EXE stage and the shared iterative Booth multiplier. Accepts one RV64M multiply op per transaction, issues it to the multiplier with the correct width and signedness, waits for the variable-latency result, selects high, low or sign-extended word, and returns it to EXE over a valid/ready pair. Handles pipeline flush at any point and never leaves the multiplier in a busy state after a flush.

## Interface

Parameters:
- XLEN, 64, operand and result width

Ports:
- clock  in  1  system clock
- reset  in  1  reset, synchronous, active-high
- req_valid  in  1  EXE presents a multiply op
- req_ready  out  1  controller can accept an op
- req_op  in  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 MULW; 5–7 reserved
- req_src1  in  XLEN  rs1 value (multiplicand)
- req_src2  in  XLEN  rs2 value (multiplier)
- resp_valid  out  1  result available
- resp_ready  in  1  EXE consumes result
- resp_data  out  XLEN  selected result
- flush  in  1  cancel any in-flight op
- mul_valid  out  1  to multiplier: start
- mul_flush  out  1  to multiplier: cancel
- mul_w  out  1  to multiplier: 32-bit op
- mul_signed  out  2  to multiplier: 2'b11 s×s, 2'b10 s×u, 2'b00 u×u
- mul_a, mul_b  out  XLEN  to multiplier: operands
- mul_ready  in  1  multiplier idle
- mul_out_valid  in  1  multiplier result valid (one-cycle pulse)
- mul_res_hi, mul_res_lo  in  XLEN  multiplier result halves

## Operation

- States: IDLE, ISSUE, WAIT, RESP.
- IDLE: req_ready=1. On req_valid: latch op, src1, src2 → ISSUE.
- ISSUE: drive mul_valid=1 with latched operands. If mul_ready → WAIT; else stay in ISSUE.
- WAIT: mul_valid=0. On mul_out_valid: capture selected result → RESP.
- RESP: resp_valid=1, resp_data stable. On resp_ready → IDLE.
- Signedness: MUL 11, MULH 11, MULHSU 10, MULHU 00, MULW 11. mul_w=1 only for MULW.
- Result select: MUL → lo; MULH/MULHSU/MULHU → hi; MULW → sign-extend lo[31:0] to XLEN.
- Reserved op codes are accepted and complete as MUL.
- Flush (any state): mul_flush=1 for that cycle iff state is ISSUE or WAIT; next state IDLE; no resp_valid is produced for the cancelled op. A flush in the same cycle as req_valid in IDLE drops the request. A flush in the same cycle as mul_out_valid discards the result.
- mul_a, mul_b, mul_w, mul_signed are driven from latched registers and stay stable from ISSUE through WAIT.

## Timing

- Reset values: state IDLE, req_ready=1, resp_valid=0, resp_data=0, mul_valid=0, mul_flush=0, mul_w=0, mul_signed=0, mul_a=mul_b=0.
- Accept in cycle N → mul_valid in N+1 → result latched in the cycle of mul_out_valid (M) → resp_valid in M+1.
- Total latency: multiplier latency + 2 cycles; multiplier latency is ≤34 cycles (≤18 for W), earlier when the multiplier operand runs out of nonzero bits.
- mul_valid is high for exactly one cycle per op when mul_ready is high; it is never held past acceptance.
- Back-to-back: an op can be accepted the cycle after resp handshake; throughput is one op per (latency + 3) cycles.
- resp_data and resp_valid are held unchanged while resp_ready=0.

## Configuration

- YSYX_040729_MUL_FUSE_EN defined: a result cache holds the last completed hi, lo, src1, src2, signedness and a valid bit. A MUL whose src1/src2 match a cached MULH (signedness 11) result, or a MULH/MULHSU/MULHU whose operands and signedness match the cache, completes IDLE → RESP in one cycle without asserting mul_valid. Cache invalidated on reset and flush; MULW never hits and does not update it.
- Not defined: every op is issued to the multiplier; no cache storage.

## Structure

- Package ysyx_040729_mul_pkg: op encoding constants, state enum, signedness constants.
- One sub-module ysyx_040729_mul_result_sel: combinational op-to-result selection (hi/lo/sext-word); the rest lives in the controller.

## Test plan

- MUL src1=3, src2=5 → resp_data=15; mul_signed=11, mul_w=0; resp_valid exactly latency+2 after accept.
- MULH src1=src2=0xFFFF_FFFF_FFFF_FFFF → resp_data=0; MULHU same operands → 0xFFFF_FFFF_FFFF_FFFE; MULHSU src1=-1, src2=2 → 0xFFFF_FFFF_FFFF_FFFF.
- MULW src1=0x7FFF_FFFF, src2=2 → resp_data=0xFFFF_FFFF_FFFF_FFFE, mul_w=1.
- Flush 5 cycles into WAIT → one-cycle mul_flush, no resp_valid, req_ready=1 next cycle; following MUL 7×6 returns 42.
- resp_ready low for 3 cycles in RESP → resp_valid and resp_data unchanged, req_ready=0 throughout.
- With YSYX_040729_MUL_FUSE_EN: MULH 0x1_0000_0000 × 0x1_0000_0003, then MUL same operands → second resp_data=0x3_0000_0000 one cycle after accept, mul_valid never asserted; after a flush the same MUL issues normally.
